// File: rtl/spi_pkg.sv
// Shared SPI definitions: default frame width, bit-order encodings and the
// shift-engine frame state type.
package spi_pkg;

  localparam int SPI_DATA_W_DEFAULT = 8;

  localparam logic SPI_LSB_FIRST = 1'b1;
  localparam logic SPI_MSB_FIRST = 1'b0;

  // Frame state; IDLE must encode as 0 so busy reads 0 out of reset.
  typedef enum logic {
    SPI_IDLE     = 1'b0,
    SPI_SHIFTING = 1'b1
  } spi_state_e;

endpackage : spi_pkg

// File: rtl/spi_bit_counter.sv
// Down-counter with load, decrement and last-bit flag. Decrement saturates
// at zero so the count can never wrap. Also used for SCLK edge counting.
module spi_bit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;

  // Next count: load has priority, decrement only while non-zero.
  always_comb begin
    count_nxt_s = count_r;
    if (load) begin
      count_nxt_s = load_val;
    end else if (dec && (count_r != CNT_ZERO)) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= CNT_ZERO;
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign count = count_r;
  assign last  = (count_r == CNT_ONE);

endmodule : spi_bit_counter

// File: rtl/spi_shift_engine.sv
// SPI data-path shifter: full-duplex DATA_W-bit shift register with frame
// tracking (busy/done), selectable bit order and a received-word register.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W_DEFAULT,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] parallel_in,
  input  logic              lsb_first,
  input  logic              shift,
  input  logic              serial_in,
  output logic              serial_out,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] parallel_out
);

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  spi_state_e        state_r;
  spi_state_e        state_nxt_s;
  logic [DATA_W-1:0] data_r;
  logic [DATA_W-1:0] data_nxt_s;
  logic [DATA_W-1:0] shifted_s;
  logic              order_r;
  logic              order_nxt_s;
  logic [DATA_W-1:0] pout_r;
  logic [DATA_W-1:0] pout_nxt_s;
  logic              done_r;
  logic              done_nxt_s;
  logic              cnt_load_s;
  logic              cnt_dec_s;
  logic [CNT_W-1:0]  cnt_s;
  logic              cnt_last_s;
  logic              shift_ok_s;

  spi_bit_counter #(
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_s),
    .load_val (CNT_FULL),
    .dec      (cnt_dec_s),
    .count    (cnt_s),
    .last     (cnt_last_s)
  );

  // Post-shift data word for the frame's latched bit order.
  always_comb begin
    shifted_s = data_r;
    if (order_r == SPI_LSB_FIRST) begin
      shifted_s = {serial_in, data_r[DATA_W-1:1]};
    end else begin
      shifted_s = {data_r[DATA_W-2:0], serial_in};
    end
  end

  // A strobe is only honoured mid-frame; a zero count there would be
  // inconsistent state, so it is treated as nothing to shift.
  assign shift_ok_s = shift && (cnt_s != CNT_ZERO);

  // Next-state and data-path control: load aborts/starts a frame and
  // swallows a coincident shift; the last accepted bit closes the frame.
  always_comb begin
    state_nxt_s = state_r;
    data_nxt_s  = data_r;
    order_nxt_s = order_r;
    pout_nxt_s  = pout_r;
    done_nxt_s  = 1'b0;
    cnt_load_s  = 1'b0;
    cnt_dec_s   = 1'b0;
    if (load) begin
      state_nxt_s = SPI_SHIFTING;
      data_nxt_s  = parallel_in;
      order_nxt_s = lsb_first;
      cnt_load_s  = 1'b1;
    end else begin
      case (state_r)
        SPI_IDLE: begin
          state_nxt_s = SPI_IDLE;
        end
        SPI_SHIFTING: begin
          if (shift_ok_s) begin
            data_nxt_s = shifted_s;
            cnt_dec_s  = 1'b1;
            if (cnt_last_s) begin
              state_nxt_s = SPI_IDLE;
              done_nxt_s  = 1'b1;
              pout_nxt_s  = shifted_s;
            end else begin
              state_nxt_s = SPI_SHIFTING;
            end
          end else begin
            state_nxt_s = SPI_SHIFTING;
          end
        end
        default: begin
          state_nxt_s = SPI_IDLE;
        end
      endcase
    end
  end

  // Frame state, shift register and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= SPI_IDLE;
      data_r  <= DATA_ZERO;
      order_r <= SPI_MSB_FIRST;
      pout_r  <= DATA_ZERO;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      data_r  <= data_nxt_s;
      order_r <= order_nxt_s;
      pout_r  <= pout_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  assign serial_out   = (order_r == SPI_LSB_FIRST) ? data_r[0] : data_r[DATA_W-1];
  assign busy         = (state_r == SPI_SHIFTING);
  assign done         = done_r;
  assign parallel_out = pout_r;

endmodule : spi_shift_engine

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench: directed and random frames on an 8-bit engine, plus
// loopback frames on 2/16/32-bit engines, against a bit-order reference model.
module tb_spi_shift_engine;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // 8-bit engine, driven directly
  logic       ld8 = 1'b0, lsb8 = 1'b0, sh8 = 1'b0, sin8 = 1'b0;
  logic [7:0] pin8 = 8'h00;
  logic       sout8, busy8, done8;
  logic [7:0] pout8;

  // sweep engines in loopback, sharing strobes
  logic        ldw = 1'b0, lsbw = 1'b0, shw = 1'b0;
  logic [1:0]  pin2 = 2'h0;
  logic [15:0] pin16 = 16'h0;
  logic [31:0] pin32 = 32'h0;
  wire         so2, so16, so32;
  logic        busy2, busy16, busy32, done2, done16, done32;
  logic [1:0]  pout2;
  logic [15:0] pout16;
  logic [31:0] pout32;

  int n_cmp = 0;
  int n_err = 0;

  // model state for the 8-bit engine
  logic       ord8 = 1'b0;
  logic [7:0] pout_m = 8'h00;

  always #5 clk = ~clk;

  spi_shift_engine #(.DATA_W(8)) dut8 (
    .clk(clk), .rst(rst), .load(ld8), .parallel_in(pin8), .lsb_first(lsb8),
    .shift(sh8), .serial_in(sin8), .serial_out(sout8), .busy(busy8),
    .done(done8), .parallel_out(pout8));

  spi_shift_engine #(.DATA_W(2)) dut2 (
    .clk(clk), .rst(rst), .load(ldw), .parallel_in(pin2), .lsb_first(lsbw),
    .shift(shw), .serial_in(so2), .serial_out(so2), .busy(busy2),
    .done(done2), .parallel_out(pout2));

  spi_shift_engine #(.DATA_W(16)) dut16 (
    .clk(clk), .rst(rst), .load(ldw), .parallel_in(pin16), .lsb_first(lsbw),
    .shift(shw), .serial_in(so16), .serial_out(so16), .busy(busy16),
    .done(done16), .parallel_out(pout16));

  spi_shift_engine #(.DATA_W(32)) dut32 (
    .clk(clk), .rst(rst), .load(ldw), .parallel_in(pin32), .lsb_first(lsbw),
    .shift(shw), .serial_in(so32), .serial_out(so32), .busy(busy32),
    .done(done32), .parallel_out(pout32));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start an 8-bit frame; parallel_out must keep the last completed word.
  task automatic load8(input logic [7:0] tx, input logic ord);
    ld8 = 1'b1; pin8 = tx; lsb8 = ord;
    tick();
    ld8 = 1'b0; pin8 = $urandom;
    ord8 = ord;
    chk("load_busy", 32'(busy8), 32'd1);
    chk("load_done", 32'(done8), 32'd0);
    chk("load_pout", 32'(pout8), 32'(pout_m));
  endtask

  // Shift one 8-bit frame: bit i goes out as tx[i] (LSB first) or tx[7-i].
  task automatic frame8(input logic [7:0] tx, input logic [7:0] rx, input int maxgap);
    for (int i = 0; i < 8; i++) begin
      chk("serial_out", 32'(sout8), 32'(ord8 ? tx[i] : tx[7-i]));
      sin8 = ord8 ? rx[i] : rx[7-i];
      sh8 = 1'b1;
      lsb8 = $urandom;
      tick();
      sh8 = 1'b0;
      if (i < 7) begin
        chk("mid_busy", 32'(busy8), 32'd1);
        chk("mid_done", 32'(done8), 32'd0);
        repeat ($urandom_range(maxgap, 0)) begin
          sin8 = $urandom;
          tick();
          chk("gap_done", 32'(done8), 32'd0);
        end
      end else begin
        pout_m = rx;
        chk("end_done", 32'(done8), 32'd1);
        chk("end_busy", 32'(busy8), 32'd0);
        chk("end_pout", 32'(pout8), 32'(rx));
        tick();
        chk("done_pulse", 32'(done8), 32'd0);
        chk("hold_pout", 32'(pout8), 32'(rx));
      end
    end
  endtask

  initial begin
    logic [7:0] so_prev;

    // reset dominates load
    rst = 1'b1; ld8 = 1'b1; pin8 = 8'hFF; ldw = 1'b1; pin32 = 32'hFFFF_FFFF;
    tick();
    tick();
    rst = 1'b0; ld8 = 1'b0; ldw = 1'b0;
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_pout", 32'(pout8), 32'd0);
    chk("rst_sout", 32'(sout8), 32'd0);
    chk("rst_busy32", 32'(busy32), 32'd0);
    chk("rst_pout32", pout32, 32'd0);
    tick();
    chk("rst_idle_busy", 32'(busy8), 32'd0);
    chk("rst_idle_sout", 32'(sout8), 32'd0);

    // directed frames from the plan
    load8(8'hC4, 1'b1);
    frame8(8'hC4, 8'h3C, 0);
    load8(8'hC4, 1'b0);
    frame8(8'hC4, 8'h5A, 0);

    // abort with coincident shift: load wins, full new frame needed
    load8(8'hC4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      sin8 = 1'b1; sh8 = 1'b1; tick(); sh8 = 1'b0;
    end
    ld8 = 1'b1; sh8 = 1'b1; pin8 = 8'h81; lsb8 = 1'b0;
    tick();
    ld8 = 1'b0; sh8 = 1'b0; ord8 = 1'b0;
    chk("abort_busy", 32'(busy8), 32'd1);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_pout", 32'(pout8), 32'(pout_m));
    frame8(8'h81, 8'hE7, 0);

    // strobes in idle change nothing
    so_prev = {7'd0, sout8};
    for (int i = 0; i < 5; i++) begin
      sin8 = $urandom; sh8 = 1'b1; tick(); sh8 = 1'b0;
      chk("idle_busy", 32'(busy8), 32'd0);
      chk("idle_done", 32'(done8), 32'd0);
      chk("idle_pout", 32'(pout8), 32'(pout_m));
      chk("idle_sout", 32'(sout8), 32'(so_prev));
    end

    // reset mid-frame: no done, everything cleared
    load8(8'h99, 1'b1);
    for (int i = 0; i < 3; i++) begin
      sin8 = 1'b0; sh8 = 1'b1; tick(); sh8 = 1'b0;
    end
    rst = 1'b1; tick(); rst = 1'b0;
    pout_m = 8'h00;
    chk("mrst_busy", 32'(busy8), 32'd0);
    chk("mrst_done", 32'(done8), 32'd0);
    chk("mrst_pout", 32'(pout8), 32'd0);
    chk("mrst_sout", 32'(sout8), 32'd0);

    // random frames with gaps of 0..4 idle cycles between strobes
    for (int r = 0; r < 8; r++) begin
      logic [7:0] tx, rx;
      logic ord;
      tx = $urandom; rx = $urandom; ord = $urandom;
      load8(tx, ord);
      frame8(tx, rx, 4);
    end

    // loopback sweep: each width completes after exactly DATA_W strobes
    for (int r = 0; r < 6; r++) begin
      logic [1:0]  w2;
      logic [15:0] w16;
      logic [31:0] w32;
      w2 = $urandom; w16 = $urandom; w32 = $urandom;
      ldw = 1'b1; lsbw = r[0]; pin2 = w2; pin16 = w16; pin32 = w32;
      tick();
      ldw = 1'b0; lsbw = ~lsbw;
      for (int k = 1; k <= 32; k++) begin
        shw = 1'b1; tick(); shw = 1'b0;
        chk("sw_done2", 32'(done2), 32'(k == 2));
        chk("sw_busy16", 32'(busy16), 32'(k < 16));
        chk("sw_done16", 32'(done16), 32'(k == 16));
        chk("sw_busy32", 32'(busy32), 32'(k < 32));
        chk("sw_done32", 32'(done32), 32'(k == 32));
        if (k >= 2)  chk("sw_pout2", 32'(pout2), 32'(w2));
        if (k >= 16) chk("sw_pout16", 32'(pout16), 32'(w16));
        if (k == 32) chk("sw_pout32", pout32, w32);
        if (($urandom & 32'd3) == 32'd0) tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_spi_shift_engine

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
- Parametrised SPI data-path shifter: DATA_W-bit full-duplex shift register with an internal bit counter, frame tracking and selectable bit order.
- Sits between the SPI master/slave control FSM and the user data interface.
- The control FSM supplies load and per-bit shift strobes. The engine tracks frame progress, raises busy/done and presents the received word on parallel_out.

Parameters:
- DATA_W, 8, frame width in bits; legal range 2..32.
- CNT_W, $clog2(DATA_W+1), bit-counter width; derived, not to be overridden.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- load  input  1  start frame: capture parallel_in and lsb_first
- parallel_in  input  DATA_W  word to transmit
- lsb_first  input  1  bit order for next frame; 1 = LSB first, 0 = MSB first
- shift  input  1  one-cycle strobe, advances frame by one bit
- serial_in  input  1  received bit, sampled on a shift cycle
- serial_out  output  1  current transmit bit
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse at frame completion
- parallel_out  output  DATA_W  last completed received word

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst); it is sampled only on the rising edge of clk.
- Reset values: data reg 0, bit count 0, order flag 0, busy 0, done 0, parallel_out 0. serial_out therefore reads 0.
- States (implicit in busy): IDLE (busy=0) and SHIFTING (busy=1).
- load in any state, with rst low:
  - data <= parallel_in; order flag <= lsb_first; count <= DATA_W; busy <= 1; done <= 0.
  - A load during SHIFTING aborts the current frame. parallel_out is not updated and done does not pulse.
- load and shift asserted in the same cycle: load wins and the shift is dropped.
- shift in SHIFTING, without load:
  - LSB-first: data <= {serial_in, data[DATA_W-1:1]}.
  - MSB-first: data <= {data[DATA_W-2:0], serial_in}.
  - count <= count-1.
- Last bit (shift while count==1, without load):
  - Shift as above; count <= 0; busy <= 0; done <= 1.
  - parallel_out <= the post-shift data value, written at the same edge.
  - done and the new parallel_out are therefore visible in the cycle after the final shift strobe.
- done is high for exactly one cycle; it clears on the next edge unless another frame completes.
- shift in IDLE is ignored: data, count and parallel_out are unchanged.
- serial_out (combinational from registers):
  - order flag 1 -> data[0]; order flag 0 -> data[DATA_W-1].
  - Valid from the cycle after load. It changes only on edges where a shift is accepted.
- After done, data holds the received word until the next load. serial_out then reflects received bits; the control FSM must not sample it in IDLE.
- rst wins over load and shift in the same cycle. rst mid-frame returns everything to reset values; no done pulse.
- lsb_first is sampled only on a load cycle. Changes mid-frame have no effect.
- Counter is never below 0 and never above DATA_W; no wrap-around is possible.

Decomposition:
- Package spi_pkg: SPI_DATA_W_DEFAULT = 8; order encodings SPI_LSB_FIRST = 1'b1, SPI_MSB_FIRST = 1'b0; shared with the SPI control FSM.
- Optional sub-module spi_bit_counter (CNT_W down-counter with load, decrement and last-bit flag). It is reused by the control FSM for SCLK edge counting.
- The shift register itself stays inline.

Test Plan:
- Reset: hold rst=1 for 2 cycles with load=1 and parallel_in=0xFF -> data, busy, done, parallel_out and serial_out all 0 after the release edge.
- LSB-first, DATA_W=8: load 0xC4 with lsb_first=1, then 8 shift strobes with serial_in carrying 0x3C LSB-first -> serial_out sequence 0,0,1,0,0,0,1,1; busy=1 for 8 strobes; done pulses once, the cycle after the 8th strobe; parallel_out=0x3C.
- MSB-first: load 0xC4 with lsb_first=0, then 8 strobes with serial_in carrying 0x5A MSB-first -> serial_out sequence 1,1,0,0,0,1,0,0; parallel_out=0x5A; done single pulse.
- Abort and collisions:
  - Load 0xC4, 3 shifts, then load 0x81 together with shift -> shift dropped, count back to 8, no done pulse, parallel_out unchanged.
  - The full 0x81 frame then completes normally.
- Idle and gaps:
  - 5 shift strobes while busy=0 -> no state change.
  - Gaps of 0..4 idle cycles between strobes -> same result as back-to-back strobes.
- Parameter sweep: DATA_W = 2, 16, 32 with random words in both bit orders -> loopback (serial_out tied to serial_in) returns parallel_out == parallel_in after exactly DATA_W strobes.
